// File: rtl/servant_sched_pkg.sv
// Shared types and constants for the servant RAM scheduler.
package servant_sched_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } sched_state_t;

  localparam int GW = 2;
  localparam logic [31:0] DEF_ERR_DATA = 32'hDEAD_BEEF;

  localparam int P_IBUS = 0;
  localparam int P_DBUS = 1;
  localparam int P_SBUS = 2;

endpackage

// File: rtl/servant_rr_pick.sv
// Rotating-priority encoder: first asserted request searching upward from last+1, wrapping at NM.
module servant_rr_pick
  import servant_sched_pkg::*;
#(
  parameter int NM = 3
) (
  input  logic [NM-1:0] req,
  input  logic [GW-1:0] last,
  output logic [GW-1:0] grant,
  output logic          valid
);

  logic [GW:0] idx;

  // Walk from the farthest candidate back to the nearest so the nearest set request wins.
  always_comb begin
    grant = '0;
    valid = |req;
    idx   = '0;
    for (int i = NM; i >= 1; i--) begin
      idx = {1'b0, last} + (GW+1)'(i);
      if (idx >= (GW+1)'(NM)) begin
        idx = idx - (GW+1)'(NM);
      end
      if (req[idx[GW-1:0]]) begin
        grant = idx[GW-1:0];
      end
    end
  end

endmodule

// File: rtl/servant_ram_sched.sv
// Round-robin Wishbone-classic scheduler sharing one single-port RAM among NM requesters.
// Optional ack timeout enabled by defining SERVANT_RAMSCHED_TIMEOUT_EN.
module servant_ram_sched
  import servant_sched_pkg::*;
#(
  parameter int          NM       = 3,
`ifdef SERVANT_RAMSCHED_TIMEOUT_EN
  parameter int          TIMEOUT  = 255,
`endif
  parameter logic [31:0] ERR_DATA = DEF_ERR_DATA
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_dbg_prio,
  input  logic [32*NM-1:0] i_m_adr,
  input  logic [32*NM-1:0] i_m_dat,
  input  logic [4*NM-1:0]  i_m_sel,
  input  logic [NM-1:0]    i_m_we,
  input  logic [NM-1:0]    i_m_cyc,
  output logic [32*NM-1:0] o_m_rdt,
  output logic [NM-1:0]    o_m_ack,
  output logic [31:0]      o_mem_adr,
  output logic [31:0]      o_mem_dat,
  output logic [3:0]       o_mem_sel,
  output logic             o_mem_we,
  output logic             o_mem_cyc,
  input  logic [31:0]      i_mem_rdt,
  input  logic             i_mem_ack,
  output logic [GW-1:0]    o_grant,
  output logic             o_busy,
  output logic             o_timeout
);

  sched_state_t  state_reg, state_next;
  logic [GW-1:0] grant_reg, grant_next;
  logic [GW-1:0] rr_last_reg, rr_last_next;
  logic [GW-1:0] pick_grant;
  logic          pick_valid;
  logic [GW-1:0] winner;
  logic          busy;
  logic          gcyc;
  logic          to_hit;
  logic          ack_any;
  logic [31:0]   rdt_sel;

  servant_rr_pick #(.NM(NM)) u_pick (
    .req   (i_m_cyc),
    .last  (rr_last_reg),
    .grant (pick_grant),
    .valid (pick_valid)
  );

  assign winner  = (i_dbg_prio && i_m_cyc[NM-1]) ? GW'(NM-1) : pick_grant;
  assign busy    = (state_reg == BUSY);
  assign ack_any = busy && (i_mem_ack || to_hit);
  assign rdt_sel = i_mem_ack ? i_mem_rdt : ERR_DATA;

  always_comb begin
    o_mem_adr = '0;
    o_mem_dat = '0;
    o_mem_sel = '0;
    o_mem_we  = 1'b0;
    gcyc      = 1'b0;
    for (int k = 0; k < NM; k++) begin
      if (grant_reg == GW'(k)) begin
        o_mem_adr = i_m_adr[32*k +: 32];
        o_mem_dat = i_m_dat[32*k +: 32];
        o_mem_sel = i_m_sel[4*k +: 4];
        o_mem_we  = i_m_we[k];
        gcyc      = i_m_cyc[k];
      end
    end
  end

  assign o_mem_cyc = busy && gcyc;
  assign o_grant   = grant_reg;
  assign o_busy    = busy;

  generate
    for (genvar gi = 0; gi < NM; gi++) begin : g_port
      assign o_m_ack[gi]          = ack_any && (grant_reg == GW'(gi));
      assign o_m_rdt[32*gi +: 32] = o_m_ack[gi] ? rdt_sel : 32'd0;
    end
  endgenerate

  // An ack (real or timeout) takes precedence over a requester dropping its cycle.
  always_comb begin
    state_next   = state_reg;
    grant_next   = grant_reg;
    rr_last_next = rr_last_reg;
    case (state_reg)
      IDLE: begin
        if (pick_valid) begin
          grant_next = winner;
          state_next = BUSY;
        end
      end
      BUSY: begin
        if (i_mem_ack || to_hit) begin
          state_next = IDLE;
          if (!i_dbg_prio) begin
            rr_last_next = grant_reg;
          end
        end else if (!gcyc) begin
          state_next   = IDLE;
          rr_last_next = grant_reg;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_reg   <= IDLE;
      grant_reg   <= '0;
      rr_last_reg <= GW'(NM-1);
    end else begin
      state_reg   <= state_next;
      grant_reg   <= grant_next;
      rr_last_reg <= rr_last_next;
    end
  end

`ifdef SERVANT_RAMSCHED_TIMEOUT_EN
  logic [15:0] cnt_reg;
  logic        timeout_reg;

  assign to_hit    = busy && (cnt_reg == 16'(TIMEOUT-1));
  assign o_timeout = timeout_reg;

  // Counter sits at zero in IDLE, so every BUSY entry starts counting from zero.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      cnt_reg     <= '0;
      timeout_reg <= 1'b0;
    end else begin
      cnt_reg <= (busy && state_next == BUSY) ? cnt_reg + 16'd1 : 16'd0;
      if (to_hit && !i_mem_ack) begin
        timeout_reg <= 1'b1;
      end
    end
  end
`else
  assign to_hit    = 1'b0;
  assign o_timeout = 1'b0;
`endif

endmodule

// File: tb/tb_servant_ram_sched.sv
// Directed bench for servant_ram_sched with a small registered-ack RAM model.
module tb_servant_ram_sched;
  localparam int NM = 3;

  logic          clk = 1'b0;
  logic          rst;
  logic          prio;
  logic [95:0]   m_adr, m_dat;
  logic [11:0]   m_sel;
  logic [2:0]    m_we, m_cyc;
  logic [95:0]   m_rdt;
  logic [2:0]    m_ack;
  logic [31:0]   mem_adr, mem_dat, ram_rdt;
  logic [3:0]    mem_sel;
  logic          mem_we, mem_cyc, ram_ack;
  logic [1:0]    grant;
  logic          busy, timeout;
  logic          stuck;
  logic [31:0]   mem [0:255];

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  servant_ram_sched #(
    .NM(NM)
`ifdef SERVANT_RAMSCHED_TIMEOUT_EN
    , .TIMEOUT(4)
`endif
  ) dut (
    .i_clk(clk), .i_rst(rst), .i_dbg_prio(prio),
    .i_m_adr(m_adr), .i_m_dat(m_dat), .i_m_sel(m_sel), .i_m_we(m_we), .i_m_cyc(m_cyc),
    .o_m_rdt(m_rdt), .o_m_ack(m_ack),
    .o_mem_adr(mem_adr), .o_mem_dat(mem_dat), .o_mem_sel(mem_sel), .o_mem_we(mem_we),
    .o_mem_cyc(mem_cyc), .i_mem_rdt(ram_rdt), .i_mem_ack(ram_ack),
    .o_grant(grant), .o_busy(busy), .o_timeout(timeout)
  );

  // RAM: acks one cycle after cyc, never twice in a row; stuck holds ack low
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      ram_ack <= 1'b0;
    end else begin
      ram_ack <= mem_cyc && !ram_ack && !stuck;
      if (mem_cyc && !ram_ack && !stuck) begin
        ram_rdt <= mem[mem_adr[9:2]];
        if (mem_we) begin
          for (int b = 0; b < 4; b++) begin
            if (mem_sel[b]) mem[mem_adr[9:2]][8*b +: 8] <= mem_dat[8*b +: 8];
          end
        end
      end
    end
  end

  typedef struct {
    int          port;
    logic        we;
    logic [31:0] adr;
    logic [31:0] dat;
    logic [3:0]  sel;
    logic [31:0] rdt;
  } vec_t;

  vec_t        vecs [8];
  logic [31:0] exp_rd [3];

  task automatic chk(input string nm, input logic [95:0] act, input logic [95:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end else begin
      $display("ok   %s: %0h", nm, act);
    end
  endtask

  task automatic set_port(input int p, input logic we, input logic [31:0] adr,
                          input logic [31:0] dat, input logic [3:0] sel);
    m_adr[32*p +: 32] = adr;
    m_dat[32*p +: 32] = dat;
    m_sel[4*p +: 4]   = sel;
    m_we[p]           = we;
  endtask

  // Called just after a rising edge with the DUT idle and no other requester.
  task automatic do_txn(input string nm, input int p, input logic we, input logic [31:0] adr,
                        input logic [31:0] dat, input logic [3:0] sel, input logic [31:0] rdt);
    int cnt;
    cnt = 0;
    set_port(p, we, adr, dat, sel);
    m_cyc[p] = 1'b1;
    while (cnt < 20) begin
      @(negedge clk);
      cnt++;
      if (|m_ack) break;
    end
    chk({nm, " latency"}, 96'(cnt), 96'd3);
    chk({nm, " ack"}, 96'(m_ack), 96'(3'b001 << p));
    chk({nm, " grant"}, 96'(grant), 96'(p));
    if (!we) chk({nm, " rdt"}, m_rdt, 96'(rdt) << (32*p));
    @(posedge clk); #1;
    m_cyc[p] = 1'b0;
  endtask

  // Expects n acks in the given port order, the first 3 sampled cycles in, then one per 3 cycles.
  task automatic expect_acks(input string nm, input int n, input int ports [6]);
    int got, cyc, last;
    got = 0; cyc = 0; last = 0;
    while (got < n && cyc < 60) begin
      @(negedge clk);
      cyc++;
      if (|m_ack) begin
        chk({nm, " ack"}, 96'(m_ack), 96'(3'b001 << ports[got]));
        chk({nm, " rdt"}, m_rdt, 96'(exp_rd[ports[got]]) << (32*ports[got]));
        chk({nm, " spacing"}, 96'(cyc - last), 96'd3);
        last = cyc;
        got++;
      end
    end
    chk({nm, " count"}, 96'(got), 96'(n));
  endtask

  task automatic pulse_reset();
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic stream_setup();
    set_port(0, 1'b0, 32'h100, 32'h0, 4'hF);
    set_port(1, 1'b0, 32'h104, 32'h0, 4'hF);
    set_port(2, 1'b0, 32'h108, 32'h0, 4'hF);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int cnt;
    logic [2:0] acc;

    for (int i = 0; i < 256; i++) mem[i] = 32'h0;
    vecs[0] = '{1, 1'b1, 32'h100, 32'hCAFE_0001, 4'hF, 32'h0};
    vecs[1] = '{2, 1'b1, 32'h104, 32'h1234_5678, 4'h3, 32'h0};
    vecs[2] = '{1, 1'b0, 32'h100, 32'h0,         4'hF, 32'hCAFE_0001};
    vecs[3] = '{0, 1'b0, 32'h104, 32'h0,         4'hF, 32'h0000_5678};
    vecs[4] = '{1, 1'b1, 32'h104, 32'hAABB_0000, 4'hC, 32'h0};
    vecs[5] = '{2, 1'b0, 32'h104, 32'h0,         4'hF, 32'hAABB_5678};
    vecs[6] = '{2, 1'b1, 32'h108, 32'h0102_0304, 4'h4, 32'h0};
    vecs[7] = '{0, 1'b0, 32'h108, 32'h0,         4'hF, 32'h0002_0000};
    exp_rd[0] = 32'hCAFE_0001;
    exp_rd[1] = 32'hAABB_5678;
    exp_rd[2] = 32'h0002_0000;

    rst = 1'b1; prio = 1'b0; stuck = 1'b0;
    m_adr = '0; m_dat = '0; m_sel = '0; m_we = '0; m_cyc = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst grant", 96'(grant), 96'd0);
    chk("rst busy", 96'(busy), 96'd0);
    chk("rst mem_cyc", 96'(mem_cyc), 96'd0);
    chk("rst ack", 96'(m_ack), 96'd0);
    chk("rst rdt", m_rdt, 96'd0);
    chk("rst timeout", 96'(timeout), 96'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    for (int i = 0; i < 8; i++) begin
      do_txn($sformatf("vec%0d", i), vecs[i].port, vecs[i].we, vecs[i].adr,
             vecs[i].dat, vecs[i].sel, vecs[i].rdt);
    end

    // Single read, cycle by cycle: idle, RAM cycle, ack, bubble
    set_port(1, 1'b0, 32'h100, 32'h0, 4'hF);
    m_cyc[1] = 1'b1;
    @(negedge clk);
    chk("lat idle mem_cyc", 96'(mem_cyc), 96'd0);
    @(negedge clk);
    chk("lat busy mem_cyc", 96'(mem_cyc), 96'd1);
    chk("lat busy adr", 96'(mem_adr), 96'h100);
    chk("lat busy ack", 96'(m_ack), 96'd0);
    @(negedge clk);
    chk("lat ack", 96'(m_ack), 96'b010);
    chk("lat rdt", m_rdt, 96'(32'hCAFE_0001) << 32);
    @(posedge clk); #1;
    m_cyc[1] = 1'b0;
    @(negedge clk);
    chk("lat bubble mem_cyc", 96'(mem_cyc), 96'd0);
    @(posedge clk); #1;

    // All three request continuously from reset (rr_last = 2)
    pulse_reset();
    stream_setup();
    m_cyc = 3'b111;
    expect_acks("rr", 6, '{0, 1, 2, 0, 1, 2});
    @(posedge clk); #1;
    m_cyc = '0;
    @(posedge clk); #1;

    // Leave rr_last at 0, then priority holds port 2 without moving the pointer
    do_txn("pre_prio", 0, 1'b0, 32'h100, 32'h0, 4'hF, 32'hCAFE_0001);
    stream_setup();
    prio = 1'b1;
    m_cyc = 3'b111;
    expect_acks("prio", 3, '{2, 2, 2, 0, 0, 0});
    @(posedge clk); #1;
    prio = 1'b0;
    expect_acks("rr_resume", 2, '{1, 2, 0, 0, 0, 0});
    @(posedge clk); #1;
    m_cyc = '0;
    @(posedge clk); #1;

    // Abort: port 0 granted, drops cyc mid-cycle before the RAM answers
    pulse_reset();
    stream_setup();
    stuck = 1'b1;
    m_cyc = 3'b011;
    @(negedge clk);
    @(negedge clk);
    chk("abort grant", 96'(grant), 96'd0);
    chk("abort mem_cyc before", 96'(mem_cyc), 96'd1);
    #1;
    m_cyc[0] = 1'b0;
    stuck = 1'b0;
    #1;
    chk("abort mem_cyc after", 96'(mem_cyc), 96'd0);
    chk("abort no ack", 96'(m_ack), 96'd0);
    expect_acks("after_abort", 1, '{1, 0, 0, 0, 0, 0});
    @(posedge clk); #1;
    m_cyc = '0;
    @(posedge clk); #1;

`ifdef SERVANT_RAMSCHED_TIMEOUT_EN
    // RAM never acks: fourth BUSY cycle returns the error word
    stuck = 1'b1;
    set_port(0, 1'b0, 32'h100, 32'h0, 4'hF);
    m_cyc[0] = 1'b1;
    cnt = 0;
    while (cnt < 20) begin
      @(negedge clk);
      cnt++;
      if (|m_ack) break;
    end
    chk("to latency", 96'(cnt), 96'd5);
    chk("to ack", 96'(m_ack), 96'b001);
    chk("to rdt", m_rdt, 96'(32'hDEAD_BEEF));
    @(posedge clk); #1;
    m_cyc = '0;
    stuck = 1'b0;
    chk("to flag set", 96'(timeout), 96'd1);
    repeat (3) @(posedge clk);
    #1;
    chk("to flag sticky", 96'(timeout), 96'd1);
    chk("to idle", 96'(busy), 96'd0);
    rst = 1'b1;
    #2;
    chk("to flag reset", 96'(timeout), 96'd0);
    rst = 1'b0;
    @(posedge clk); #1;
`endif

    // Reset pulse in the middle of a BUSY cycle
    stuck = 1'b1;
    set_port(1, 1'b0, 32'h104, 32'h0, 4'hF);
    m_cyc[1] = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("mid busy", 96'(busy), 96'd1);
    chk("mid grant", 96'(grant), 96'd1);
    #1;
    rst = 1'b1;
    #1;
    chk("mid rst busy", 96'(busy), 96'd0);
    chk("mid rst mem_cyc", 96'(mem_cyc), 96'd0);
    chk("mid rst grant", 96'(grant), 96'd0);
    chk("mid rst ack", 96'(m_ack), 96'd0);
    chk("mid rst timeout", 96'(timeout), 96'd0);
    m_cyc = '0;
    stuck = 1'b0;
    #1;
    rst = 1'b0;
    acc = '0;
    repeat (5) begin
      @(negedge clk);
      acc = acc | m_ack;
    end
    chk("mid rst no ack", 96'(acc), 96'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
